// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: instruction encoding constants and fetch state.
package cpu_pkg;

  localparam logic [7:0] HALT_INST = 8'h0F;

  // Opcode field is inst[3:2], function field inst[1:0]
  localparam logic [1:0] OPC_ALU = 2'b00;
  localparam logic [1:0] OPC_LD  = 2'b01;
  localparam logic [1:0] OPC_BR  = 2'b10;
  localparam logic [1:0] OPC_SYS = 2'b11;
  localparam logic [1:0] FN_HALT = 2'b11;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [7:0] inst);
    return (inst[7:4] == 4'h0) && (inst[3:2] == OPC_SYS) && (inst[1:0] == FN_HALT);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {instruction, pc} queue; entry 0 is always the head. Flush beats push/pop.
module fetch_fifo #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [7:0]      push_inst,
  input  logic [PC_W-1:0] push_pc,
  output logic [7:0]      head_inst,
  output logic [PC_W-1:0] head_pc,
  output logic [1:0]      count,
  output logic            full,
  output logic            empty
);

  typedef struct packed {
    logic [7:0]      inst;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t     ent0_r, ent1_r, wr_s;
  logic [1:0] count_r, count_nxt_s;
  logic       full_r, empty_r;

  // next occupancy
  always_comb begin
    wr_s        = '{inst: push_inst, pc: push_pc};
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else if (push && !pop) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop && !push) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // storage, occupancy and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_r  <= '0;
      ent1_r  <= '0;
      count_r <= 2'd0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == 2'd2);
      empty_r <= (count_nxt_s == 2'd0);
      if (!flush) begin
        case ({push, pop})
          2'b10: begin
            if (count_r == 2'd0) ent0_r <= wr_s;
            else                 ent1_r <= wr_s;
          end
          2'b01: ent0_r <= ent1_r;
          2'b11: begin
            if (count_r == 2'd1) begin
              ent0_r <= wr_s;
            end else begin
              ent0_r <= ent1_r;
              ent1_r <= wr_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign head_inst = ent0_r.inst;
  assign head_pc   = ent0_r.pc;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

endmodule

// File: rtl/fetch_fifo_chk.sv
// Checker for the fetch queue: the issue logic must never push into a full queue.
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, read issue to a registered-output memory, return queue,
// redirect flush and HALT stop.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic [7:0]      inst_out,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  fetch_state_t    state_r;
  logic [PC_W-1:0] fetch_pc_r, issue_pc_r;
  logic            inflight_r, kill_r, run_r, halted_r;
  logic [1:0]      count_s, occ_s;
  logic            full_s, empty_s;
  logic            transfer_s, issue_s, push_s, halt_ret_s;

  // issue decision; run_r holds off the first read until one edge after reset
  always_comb begin
    transfer_s = !empty_s && inst_ready;
    push_s     = inflight_r && !kill_r;
    halt_ret_s = push_s && is_halt(imem_data);
    occ_s      = count_s + {1'b0, inflight_r};
    if (run_r && (state_r == RUN) && !redirect_valid) begin
      issue_s = (occ_s < 2'd2) || transfer_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC, in-flight tracking and RUN/HALTED state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      issue_pc_r <= RESET_PC;
      state_r    <= RUN;
      inflight_r <= 1'b0;
      kill_r     <= 1'b0;
      run_r      <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      run_r      <= 1'b1;
      inflight_r <= issue_s;
      // a read issued alongside the returning HALT must not reach the queue
      kill_r     <= issue_s && halt_ret_s;
      if (issue_s) issue_pc_r <= fetch_pc_r;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
        state_r    <= RUN;
        halted_r   <= 1'b0;
      end else begin
        if (issue_s) fetch_pc_r <= fetch_pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        case (state_r)
          RUN: begin
            if (halt_ret_s) begin
              state_r  <= HALTED;
              halted_r <= 1'b1;
            end
          end
          HALTED:  halted_r <= 1'b1;
          default: begin
            state_r  <= RUN;
            halted_r <= 1'b0;
          end
        endcase
      end
    end
  end

  fetch_fifo #(.PC_W(PC_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (transfer_s),
    .flush     (redirect_valid),
    .push_inst (imem_data),
    .push_pc   (issue_pc_r),
    .head_inst (inst_out),
    .head_pc   (inst_pc),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  fetch_fifo_chk u_fifo_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .full (full_s)
  );

  assign imem_en    = issue_s;
  assign imem_addr  = fetch_pc_r;
  assign inst_valid = !empty_s;
  assign halted     = halted_r;

endmodule
